ram_scheduler: RTL
==================

# ram_scheduler

Single-clock sequencer and RAM arbiter for the four-stage processor pipeline. It generates the stage index and per-stage capture enables that replace the multi-phase clock. It also shares the single RAM port between the pipeline and a DMA requester (boot loader / IO copy engine), with CPU priority and a starvation guard that stalls the pipeline for one cycle.

## Interface
- ADDR_W, 16, RAM address width
- DATA_W, 32, RAM data width
- STARVE_LIMIT, 8, DMA-denied RUN cycles before a forced stall (legal range 1..255)

- clk  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- power_on  in  1  pipeline enabled; 0 freezes stages
- stage  out  2  current pipeline stage 0..3
- stage_en  out  4  one-hot capture enable for `stage`; all-zero when not RUN
- cpu_ram_req  in  1  current stage needs RAM this cycle
- cpu_ram_addr  in  ADDR_W  pipeline address
- cpu_ram_we  in  1  pipeline write
- cpu_ram_wdata  in  DATA_W  pipeline write data
- dma_req  in  1  DMA transfer pending; held until ack
- dma_addr  in  ADDR_W  DMA address, stable while req
- dma_we  in  1  DMA write, stable while req
- dma_wdata  in  DATA_W  DMA write data, stable while req
- dma_ack  out  1  one-cycle pulse, transfer done
- dma_rdata  out  DATA_W  read data, valid with dma_ack
- ram_addr  out  ADDR_W  to RAM
- ram_we  out  1  to RAM, commits at clk edge
- ram_wdata  out  DATA_W  to RAM
- ram_rdata  in  DATA_W  RAM combinational read data

## Operation
- States: RUN, STALL, HALT. Registers: state, stage, wait_cnt, dma_ack, dma_rdata.
- RUN: stage_en = onehot(stage); stage advances 0→1→2→3→0 every cycle.
- STALL: lasts exactly one cycle. stage holds, stage_en = 0, DMA owns RAM. Returns to RUN, or to HALT if power_on = 0.
- HALT: entered from any state when power_on = 0. stage holds, stage_en = 0, DMA may own RAM every eligible cycle. Exits to RUN when power_on = 1 and resumes at the held stage. HALT has priority over STALL.
- Ownership (combinational, per cycle):
  - CPU owns RAM if state = RUN and cpu_ram_req.
  - Otherwise DMA owns RAM if dma_req and dma_ack = 0.
  - Otherwise there is no owner: ram_we = 0 and ram_addr/ram_wdata = 0.
- ram_* is driven by a mux from the owner. ram_we is forced 0 while reset_n is low.
- DMA owned cycle: dma_rdata <= ram_rdata and dma_ack <= 1 at the edge; dma_ack clears the following cycle.
- A DMA grant is blocked in the cycle dma_ack = 1, so back-to-back DMA is at most one transfer per 2 cycles. dma_req still high in the ack cycle denotes a new transfer.
- wait_cnt:
  - increments in RUN cycles with dma_req = 1, dma_ack = 0, and CPU owning RAM;
  - clears on any DMA grant, and when dma_req = 0;
  - saturates at STARVE_LIMIT.
  - When wait_cnt = STARVE_LIMIT in RUN, the next state is STALL. Width: 8 bits.
- Reset values: state = RUN, stage = 0, stage_en = 0001, wait_cnt = 0, dma_ack = 0, dma_rdata = 0, ram_we = 0.
- Reset mid-transfer: the transfer is dropped with no ack; the requester re-issues. A write already committed at an earlier edge stands.

## Timing
- Grant is combinational in the request cycle. Write commits at that cycle's rising edge. dma_ack and dma_rdata are valid the next cycle.
- DMA latency from req to commit edge:
  - best case 1 cycle;
  - worst case in RUN, STARVE_LIMIT+1 cycles (the forced STALL);
  - in HALT, 1 cycle.
- A stall costs the pipeline exactly one cycle; no stage_en pulse is lost or duplicated.
- power_on falling: the current-cycle state is still decoded from registers; HALT takes effect from the next edge.

## Structure
- Package ram_scheduler_pkg: state enum {RUN, STALL, HALT}; stage constants STAGE_FETCH=0, STAGE_READ=1, STAGE_EXEC=2, STAGE_WRITE=3; owner enum {OWN_NONE, OWN_CPU, OWN_DMA}.
- One sub-module: dma_starve_counter (wait_cnt with saturate, clear, and limit-hit output). The FSM, mux, and ack register stay in the top module.

## Test plan
- Release reset with power_on=1 and no requests: stage goes 0,1,2,3,0; stage_en goes 0001,0010,0100,1000,0001; ram_we=0.
- cpu_ram_req=0 at stage 2, DMA write to addr 0x0010 data 0xDEADBEEF: ram_we=1 that cycle; dma_ack pulses next cycle; a later DMA read of 0x0010 returns 0xDEADBEEF.
- cpu_ram_req=1 permanently with dma_req held, STARVE_LIMIT=8: exactly 8 RUN cycles denied, then one STALL cycle with stage_en=0000 and the DMA grant, then stages resume from the held value.
- power_on=0 with a DMA read stream: stage frozen; acks on every second cycle. Raise power_on: RUN resumes at the frozen stage.
- Assert reset_n=0 in a DMA-granted cycle before the edge: no ack; all registers at reset values; ram_we=0 immediately.
- STALL pending and power_on=0 in the same cycle: next state HALT; no STALL cycle is counted.

Source files
------------

// File: rtl/ram_scheduler_pkg.sv
// Shared types and constants for the pipeline sequencer / RAM arbiter.
package ram_scheduler_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      STALL = 2'd1,
      HALT  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_DMA  = 2'd2
   } owner_t;

   localparam logic [1:0] STAGE_FETCH = 2'd0;
   localparam logic [1:0] STAGE_READ  = 2'd1;
   localparam logic [1:0] STAGE_EXEC  = 2'd2;
   localparam logic [1:0] STAGE_WRITE = 2'd3;

   localparam int WAIT_W = 8;

   function automatic logic [3:0] stage_onehot(input logic [1:0] s);
      return 4'b0001 << s;
   endfunction

endpackage

// File: rtl/dma_starve_counter.sv
// Counts RUN cycles in which a pending DMA request was denied by the CPU.
// The limit flag looks at the count including the current cycle, so the
// forced stall directly follows the LIMIT-th denied cycle.
module dma_starve_counter
   import ram_scheduler_pkg::*;
#(
   parameter int LIMIT = 8
) (
   input  logic clk,
   input  logic reset_n,
   input  logic inc,
   input  logic clr,
   output logic limit_hit
);

   localparam logic [WAIT_W-1:0] LIMIT_V = WAIT_W'(LIMIT);

   logic [WAIT_W-1:0] cnt;
   logic [WAIT_W-1:0] cnt_nxt;

   // next count: clear wins over increment, increment saturates at the limit
   always_comb begin
      cnt_nxt = cnt;
      if (clr) begin
         cnt_nxt = '0;
      end else if (inc && (cnt != LIMIT_V)) begin
         cnt_nxt = cnt + WAIT_W'(1);
      end
   end

   assign limit_hit = (cnt_nxt == LIMIT_V);

   // count register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_nxt;
      end
   end

endmodule

// File: rtl/ram_scheduler.sv
// Pipeline stage sequencer and single-port RAM arbiter (CPU priority, DMA
// starvation guard via a one-cycle pipeline stall).
//
//   state | meaning
//   RUN   | stages advance, stage_en one-hot, CPU may own RAM
//   STALL | single cycle, stage held, stage_en 0, DMA owns RAM
//   HALT  | power_on low, stage held, stage_en 0, DMA may own RAM
module ram_scheduler
   import ram_scheduler_pkg::*;
#(
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              power_on,
   output logic [1:0]        stage,
   output logic [3:0]        stage_en,
   input  logic              cpu_ram_req,
   input  logic [ADDR_W-1:0] cpu_ram_addr,
   input  logic              cpu_ram_we,
   input  logic [DATA_W-1:0] cpu_ram_wdata,
   input  logic              dma_req,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic              dma_we,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_ack,
   output logic [DATA_W-1:0] dma_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   state_t state;
   state_t state_nxt;
   owner_t owner;
   logic   ram_we_mux;
   logic   limit_hit;
   logic   cnt_inc;
   logic   cnt_clr;

   // state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= RUN;
      end else begin
         state <= state_nxt;
      end
   end

   // next state: power-down beats a pending stall
   always_comb begin
      state_nxt = state;
      if (!power_on) begin
         state_nxt = HALT;
      end else begin
         case (state)
            RUN:     if (limit_hit) state_nxt = STALL;
            STALL:   state_nxt = RUN;
            HALT:    state_nxt = RUN;
            default: state_nxt = RUN;
         endcase
      end
   end

   // outputs: stage enables, RAM ownership and the RAM port mux
   always_comb begin
      stage_en   = '0;
      owner      = OWN_NONE;
      ram_addr   = '0;
      ram_wdata  = '0;
      ram_we_mux = 1'b0;
      if (state == RUN) begin
         stage_en = stage_onehot(stage);
      end
      if ((state == RUN) && cpu_ram_req) begin
         owner = OWN_CPU;
      end else if (dma_req && !dma_ack) begin
         owner = OWN_DMA;
      end
      case (owner)
         OWN_CPU: begin
            ram_addr   = cpu_ram_addr;
            ram_wdata  = cpu_ram_wdata;
            ram_we_mux = cpu_ram_we;
         end
         OWN_DMA: begin
            ram_addr   = dma_addr;
            ram_wdata  = dma_wdata;
            ram_we_mux = dma_we;
         end
         default: ;
      endcase
   end

   // a write must never reach the RAM while reset is held, even mid-cycle
   assign ram_we = ram_we_mux & reset_n;

   assign cnt_inc = (state == RUN) && dma_req && !dma_ack && (owner == OWN_CPU);
   assign cnt_clr = (owner == OWN_DMA) || !dma_req;

   dma_starve_counter #(
      .LIMIT(STARVE_LIMIT)
   ) u_starve (
      .clk       (clk),
      .reset_n   (reset_n),
      .inc       (cnt_inc),
      .clr       (cnt_clr),
      .limit_hit (limit_hit)
   );

   // stage advance and DMA completion registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stage     <= STAGE_FETCH;
         dma_ack   <= 1'b0;
         dma_rdata <= '0;
      end else begin
         if (state == RUN) begin
            stage <= stage + 2'd1;
         end
         dma_ack <= (owner == OWN_DMA);
         if (owner == OWN_DMA) begin
            dma_rdata <= ram_rdata;
         end
      end
   end

endmodule
